// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin 8:1 mux arbiter: requester count,
// select width, FSM encoding and the combinational round-robin search.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Result of one round-robin search: winner index plus whether any request was seen.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Search order is ptr, ptr+1, ... ptr+7 (mod 8); the first set request wins.
  // Walking the offsets from highest to lowest lets the smallest offset
  // overwrite the result last, so it has the highest priority.
  function automatic rr_pick_t rr_search(input logic [N_REQ-1:0] req,
                                         input logic [SEL_W-1:0] ptr);
    rr_pick_t         res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      // Index arithmetic is SEL_W bits wide, so ptr+7 wraps naturally.
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux8x1.sv
// Plain 8:1 single-bit multiplexer on the shared output path.
module mux8x1 (
  input  logic [7:0] i_data,
  input  logic [2:0] i_sel,
  output logic       o_data
);

  assign o_data = i_data[i_sel];

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit mux among eight requesters.
// One requester holds the path for at most MAX_HOLD consecutive cycles; on
// release the next winner is granted at the following edge with no bubble.
module rr_mux8_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,  // legal range 1..16
  parameter int CNT_W    = 4   // 2**CNT_W >= MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic [N_REQ-1:0] r_gnt;

  arb_state_e       w_state_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;

  logic             w_release;
  logic [SEL_W-1:0] w_search_ptr;
  rr_pick_t         w_pick;
  logic             w_mux_raw;

  // A tenure ends when its owner drops the request or the hold limit is reached.
  always_comb begin
    w_release    = (r_state == ST_GRANT) && (!req[r_sel] || (r_cnt == CNT_LAST));
    // On release the search already starts past the releasing requester,
    // so it ranks lowest and is only re-granted if nobody else is asking.
    w_search_ptr = w_release ? (r_sel + SEL_W'(1)) : r_ptr;
    w_pick       = rr_search(req, w_search_ptr);
  end

  // Next-state logic: arbitration, tenure counting and pointer advance.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;

    case (r_state)
      ST_IDLE: begin
        if (w_pick.found) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_pick.idx;
          w_gnt_nxt   = N_REQ'(1) << w_pick.idx;
          w_cnt_nxt   = '0;
        end
      end

      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_search_ptr;
          if (w_pick.found) begin
            w_sel_nxt = w_pick.idx;
            w_gnt_nxt = N_REQ'(1) << w_pick.idx;
            w_cnt_nxt = '0;
          end else begin
            // sel keeps its last value while idle; out is masked by valid.
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled only on the clock edge, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  mux8x1 u_mux (
    .i_data (in),
    .i_sel  (r_sel),
    .o_data (w_mux_raw)
  );

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = (r_state == ST_GRANT);
  assign out   = w_mux_raw & valid;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Bench for rr_mux8_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=2) share
// one stimulus stream and are compared every cycle against a behavioural
// model of owners, tenure lengths and a rotating priority start point.
module tb_rr_mux8_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din;

  logic [7:0] gnt4, gnt2;
  logic [2:0] sel4, sel2;
  logic       valid4, valid2, out4, out2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rr_mux8_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .in(din),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .out(out4)
  );

  rr_mux8_arbiter #(.MAX_HOLD(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .in(din),
    .gnt(gnt2), .sel(sel2), .valid(valid2), .out(out2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int hold_lim [2] = '{4, 2};
  int owner    [2];       // granted requester, -1 when idle
  int held     [2];       // cycles the current owner has been granted
  int prio     [2];       // requester that is searched first
  int wait_cnt [2][8];    // cycles spent requesting without a grant

  function automatic int first_from(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; held[d] = 0; prio[d] = 0;
      for (int i = 0; i < 8; i++) wait_cnt[d][i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        owner[d] = -1; held[d] = 0; prio[d] = 0;
      end else if (owner[d] < 0) begin
        owner[d] = first_from(req, prio[d]);
        held[d]  = (owner[d] >= 0) ? 1 : 0;
      end else if (!req[owner[d]] || held[d] == hold_lim[d]) begin
        prio[d]  = (owner[d] + 1) % 8;
        owner[d] = first_from(req, prio[d]);
        held[d]  = (owner[d] >= 0) ? 1 : 0;
      end else begin
        held[d]++;
      end
      for (int i = 0; i < 8; i++) begin
        if (rst || !req[i] || owner[d] == i) wait_cnt[d][i] = 0;
        else wait_cnt[d][i]++;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [7:0] a_gnt;
      logic [2:0] a_sel;
      logic       a_valid, a_out;
      logic [7:0] e_gnt;
      int         worst;
      a_gnt   = (d == 0) ? gnt4   : gnt2;
      a_sel   = (d == 0) ? sel4   : sel2;
      a_valid = (d == 0) ? valid4 : valid2;
      a_out   = (d == 0) ? out4   : out2;
      e_gnt   = (owner[d] < 0) ? 8'h00 : (8'h01 << owner[d]);
      check($sformatf("h%0d_gnt", hold_lim[d]), {24'd0, a_gnt}, {24'd0, e_gnt});
      check($sformatf("h%0d_valid", hold_lim[d]), {31'd0, a_valid}, {31'd0, owner[d] >= 0});
      check($sformatf("h%0d_out", hold_lim[d]), {31'd0, a_out},
            {31'd0, (owner[d] >= 0) ? din[owner[d]] : 1'b0});
      if (owner[d] >= 0)
        check($sformatf("h%0d_sel", hold_lim[d]), {29'd0, a_sel}, owner[d]);
      worst = 0;
      for (int i = 0; i < 8; i++) if (wait_cnt[d][i] > worst) worst = wait_cnt[d][i];
      check($sformatf("h%0d_wait_bound", hold_lim[d]), {31'd0, worst <= 7 * hold_lim[d]}, 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] e_sel;
    rst = 1'b1;
    req = 8'hFF;
    din = 8'h00;

    // Reset held for two cycles with every request up.
    step();
    step();
    check("rst_gnt",   {24'd0, gnt4},   32'h00);
    check("rst_sel",   {29'd0, sel4},   32'h0);
    check("rst_valid", {31'd0, valid4}, 32'h0);
    check("rst_out",   {31'd0, out4},   32'h0);
    rst = 1'b0;
    step();
    check("first_gnt_h4", {24'd0, gnt4}, 32'h01);
    check("first_gnt_h2", {24'd0, gnt2}, 32'h01);

    // Single requester 3, re-granted every MAX_HOLD cycles without a bubble.
    do_reset();
    req = 8'h08;
    din = 8'b1010_1010;
    step();
    check("single_sel", {29'd0, sel4}, 32'd3);
    check("single_out", {31'd0, out4}, 32'd1);
    check("single_gnt", {24'd0, gnt4}, 32'h08);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("single_regrant_valid", {31'd0, valid4}, 32'd1);
      check("single_regrant_sel", {29'd0, sel4}, 32'd3);
      if (k % 4 == 0) check("single_regrant_cnt", {28'd0, u_dut4.r_cnt}, 32'd0);
    end
    req = 8'h00;
    step();
    check("single_drop_valid", {31'd0, valid4}, 32'd0);
    check("single_drop_out", {31'd0, out4}, 32'd0);

    // Full rotation with MAX_HOLD=2: 0,0,1,1,...,7,7,0.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k <= 16; k++) begin
      din = 8'($urandom);
      step();
      e_sel = 3'((k / 2) % 8);
      check("rot_sel", {29'd0, sel2}, {29'd0, e_sel});
      check("rot_out", {31'd0, out2}, {31'd0, din[e_sel]});
    end

    // Early release of requester 2 while 5 waits.
    do_reset();
    req = 8'h24;
    step();
    check("early_first_sel", {29'd0, sel4}, 32'd2);
    req = 8'h20;
    step();
    check("early_next_sel", {29'd0, sel4}, 32'd5);
    check("early_ptr", {29'd0, u_dut4.r_ptr}, 32'd3);

    // Fairness: 6 finishes with req=0x41, so 0 goes next, then 6 again.
    do_reset();
    req = 8'h40;
    step();
    check("fair_first_sel", {29'd0, sel4}, 32'd6);
    req = 8'h41;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("fair_sel", {29'd0, sel4}, (k >= 4 && k <= 7) ? 32'd0 : 32'd6);
    end

    // Reset in the middle of a tenure of requester 4 (cnt=1, ptr=6).
    do_reset();
    req = 8'h20;
    step();
    req = 8'h10;
    step();
    check("midrst_pre_sel", {29'd0, sel4}, 32'd4);
    check("midrst_pre_ptr", {29'd0, u_dut4.r_ptr}, 32'd6);
    step();
    check("midrst_pre_cnt", {28'd0, u_dut4.r_cnt}, 32'd1);
    rst = 1'b1;
    step();
    check("midrst_gnt",   {24'd0, gnt4},   32'h00);
    check("midrst_valid", {31'd0, valid4}, 32'd0);
    check("midrst_sel",   {29'd0, sel4},   32'd0);
    check("midrst_out",   {31'd0, out4},   32'd0);
    rst = 1'b0;
    req = 8'h10;
    step();
    check("midrst_regrant_sel", {29'd0, sel4}, 32'd4);
    check("midrst_ptr", {29'd0, u_dut4.r_ptr}, 32'd0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      din = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       req = 8'($urandom | $urandom);
          1:       req = 8'($urandom & $urandom);
          default: req = 8'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_mux8_arbiter.md
# rr_mux8_arbiter

- Round-robin arbiter and sequencer that shares one 8:1 single-bit mux path among eight requesters.
- Each requester raises `req[i]` while its data bit `in[i]` is to be routed to the shared output.
- The block grants one requester at a time, drives the 3-bit mux select, and bounds each tenure to `MAX_HOLD` cycles.
- It sits between the requesting logic and the shared output pin or register on the Spartan-7 board.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per tenure; legal range 1..16.
- `CNT_W`, default 4: hold-counter width; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `req` input 8: per-requester request, level-sensitive.
- `in` input 8: per-requester data bit.
- `gnt` output 8: one-hot grant, registered; all zero when idle.
- `sel` output 3: registered mux select; equals the index of the set `gnt` bit.
- `valid` output 1: high while a grant is active.
- `out` output 1: `in[sel]` when `valid`, else 0; combinational from the registered `sel`.

## Operation
- State machine has two states.
  - IDLE: `gnt`=0, `valid`=0.
  - GRANT: exactly one `gnt` bit set.
- Priority pointer `ptr` (3 bits):
  - Search order is `ptr`, `ptr+1`, … `ptr+7`, mod 8; the first set `req` wins.
  - When a tenure of requester k ends, `ptr` <= (k+1) mod 8. Index 7 wraps to 0.
- IDLE -> GRANT when `req` != 0. The winner is loaded into `sel`/`gnt` and `cnt` <= 0.
- In GRANT, `cnt` increments each cycle. Release occurs when either:
  - `req[sel]`==0, or
  - `cnt`==MAX_HOLD-1.
- On release with other requests pending, arbitration runs in the same cycle and the next grant takes effect at the next edge. There is no idle bubble.
- The released requester is eligible again but has the lowest priority, because `ptr` now sits past it.
- On release with `req`==0, or with only the releasing requester's `req` low: GRANT -> IDLE.
- If `req[sel]` is still high at a `MAX_HOLD` release and no other request exists, the same requester is re-granted with `cnt` <= 0 and `ptr` still advanced.
- `MAX_HOLD`=1: every tenure lasts one cycle, giving a pure per-cycle rotation.
- `in` changes are unconstrained. `out` tracks `in[sel]` combinationally during a grant.

## Timing
- Reset values: `gnt`=0, `sel`=0, `valid`=0, `out`=0, `ptr`=0, `cnt`=0, state IDLE.
- `rst` has priority over every other input, including mid-tenure. Outputs clear at the edge where `rst` is sampled high.
- Request-to-grant latency is 1 cycle: `req` sampled at edge N, `gnt`/`sel`/`valid` valid after edge N.
- A deasserting `req[sel]` is seen at edge N. `gnt` drops, or moves to the next winner, after edge N.
- A requester that drops `req` while not granted is never granted.
- Maximum wait for any continuously requesting input: 7 × MAX_HOLD cycles.
- `sel` and `gnt` change only on clock edges and are always mutually consistent.

## Structure
- Shared package `mux_arb_pkg` holds:
  - `N_REQ`=8 and `SEL_W`=3;
  - the state encoding (IDLE=0, GRANT=1).
- The datapath instantiates the existing `mux8x1` sub-module with (`in`, `sel`, raw output). The block ANDs that raw output with `valid` to form `out`.
- The round-robin search is a combinational function of (`req`, `ptr`) in the package, returning winner index and found flag. No further sub-modules.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles with `req`=8'hFF. Require `gnt`=0, `sel`=0, `valid`=0, `out`=0. After release, the first grant is `gnt`=8'h01 one cycle later.
- Single requester: `req`=8'h08, `in`=8'b10101010, MAX_HOLD=4.
  - Grant `sel`=3, `out`=1 one cycle later.
  - Re-grant to 3 every 4 cycles with no bubble.
  - Drop `req`, and `valid`=0 the next cycle.
- Full rotation: `req`=8'hFF held, MAX_HOLD=2. Require `sel` sequence 0,0,1,1,…,7,7,0 with `out` following `in[sel]`. Include the 7->0 wrap.
- Early release: grant requester 2, deassert `req[2]` after 1 cycle while `req[5]` is high. Require `sel`=5 on the next edge and `ptr` advanced to 3.
- Fairness after release: requester 6 finishes while `req`=8'h41. Require the next grant is 0, not 6, then 6.
- Reset mid-tenure: `rst` pulsed during a grant to 4 at `cnt`=1.
  - Outputs clear at that edge.
  - After reset, with `req`=8'h10, the grant goes to 4 with `ptr` restarted from 0.
